// File: rtl/core_ram_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | core_ram_pkg                                                           |
// | Shared defaults and width helpers for the NTT core bank RAM.           |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
package core_ram_pkg;

  localparam int c_log_n_default      = 12;
  localparam int c_data_width_default = 60;

  // Each core holds 1/2**LOG_CORE_COUNT of the polynomial, split over 4 words per address.
  function automatic int addr_w(input int log_n, input int log_cores);
    return log_n - (log_cores + 2);
  endfunction

  function automatic int bank_w(input int num_banks);
    return (num_banks <= 2) ? 1 : $clog2(num_banks);
  endfunction

endpackage
`default_nettype wire

// File: rtl/core_ram_bank.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | core_ram_bank                                                          |
// | Simple dual-port block RAM: one write port, one registered read port.  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module core_ram_bank #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 60,
  localparam int DEPTH     = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  (* ram_style = "block" *) logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  // Output register only updates on a read, so the last word is held.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (re) begin
      r_q <= r_mem[raddr];
    end
  end

  assign rdata = r_q;

endmodule
`default_nettype wire

// File: rtl/core_bank_ram.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | core_bank_ram                                                          |
// | N-bank coefficient buffer with producer/consumer ownership handshake.  |
// | Optional macro CORE_BANK_RAM_OUT_REG_EN adds an output register stage. |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module core_bank_ram
  import core_ram_pkg::*;
#(
  parameter int  LOG_N          = c_log_n_default,
  parameter int  LOG_CORE_COUNT = 5,
  parameter int  DATA_WIDTH     = c_data_width_default,
  parameter int  NUM_BANKS      = 2,
  localparam int ADDR_WIDTH     = addr_w(LOG_N, LOG_CORE_COUNT),
  localparam int BANK_W         = bank_w(NUM_BANKS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_commit,
  output logic                  wr_ready,
  output logic [BANK_W-1:0]     wr_bank,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_release,
  output logic                  rd_ready,
  output logic [BANK_W-1:0]     rd_bank,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  err
);

  localparam logic [BANK_W-1:0] c_last_bank = BANK_W'(NUM_BANKS - 1);

  logic [BANK_W-1:0]     r_wr_ptr;
  logic [BANK_W-1:0]     r_rd_ptr;
  logic [BANK_W-1:0]     r_rd_sel;
  logic [NUM_BANKS-1:0]  r_full;
  logic                  r_rd_valid;
  logic                  r_err;
  logic                  w_wr_acc;
  logic                  w_commit_acc;
  logic                  w_rd_acc;
  logic                  w_release_acc;
  logic                  w_violation;
  logic [DATA_WIDTH-1:0] w_bank_q [NUM_BANKS];
  logic [DATA_WIDTH-1:0] w_rd_mux;

  function automatic logic [BANK_W-1:0] next_ptr(input logic [BANK_W-1:0] p);
    return (p == c_last_bank) ? '0 : p + 1'b1;
  endfunction

  assign wr_ready = !r_full[r_wr_ptr];
  assign rd_ready = r_full[r_rd_ptr];
  assign wr_bank  = r_wr_ptr;
  assign rd_bank  = r_rd_ptr;
  assign err      = r_err;

  // Reset outranks every request, so nothing is accepted while it is low.
  assign w_wr_acc      = rst_n && wr_en      && wr_ready;
  assign w_commit_acc  = rst_n && wr_commit  && wr_ready;
  assign w_rd_acc      = rst_n && rd_en      && rd_ready;
  assign w_release_acc = rst_n && rd_release && rd_ready;
  assign w_violation   = ((wr_en || wr_commit) && !wr_ready) ||
                         ((rd_en || rd_release) && !rd_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_rd_sel   <= '0;
      r_full     <= '0;
      r_rd_valid <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (w_commit_acc) begin
        r_wr_ptr <= next_ptr(r_wr_ptr);
      end
      if (w_release_acc) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      if (w_rd_acc) begin
        r_rd_sel <= r_rd_ptr;
      end
      r_rd_valid <= w_rd_acc;
      if (w_violation) begin
        r_err <= 1'b1;
      end
      // Full flags gate acceptance, so commit and release never hit the same bank.
      for (int i = 0; i < NUM_BANKS; i++) begin
        if (w_commit_acc && (r_wr_ptr == BANK_W'(i))) begin
          r_full[i] <= 1'b1;
        end else if (w_release_acc && (r_rd_ptr == BANK_W'(i))) begin
          r_full[i] <= 1'b0;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    core_ram_bank #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_bank (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (w_wr_acc && (r_wr_ptr == BANK_W'(g))),
      .waddr (wr_addr),
      .wdata (wr_data),
      .re    (w_rd_acc && (r_rd_ptr == BANK_W'(g))),
      .raddr (rd_addr),
      .rdata (w_bank_q[g])
    );
  end

  assign w_rd_mux = w_bank_q[r_rd_sel];

`ifdef CORE_BANK_RAM_OUT_REG_EN
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_out_valid <= r_rd_valid;
      if (r_rd_valid) begin
        r_out_data <= w_rd_mux;
      end
    end
  end

  assign rd_valid = r_out_valid;
  assign rd_data  = r_out_data;
`else
  assign rd_valid = r_rd_valid;
  assign rd_data  = w_rd_mux;
`endif

endmodule
`default_nettype wire

// File: tb/tb_core_bank_ram.sv
`default_nettype none
// Bench for core_bank_ram: a 2-bank and a 3-bank instance share stimulus and
// are checked every cycle against an array/queue model, plus literal expectations.
module tb_core_bank_ram;

  localparam int DW    = 60;
  localparam int AW    = 5;
  localparam int DEPTH = 32;
`ifdef CORE_BANK_RAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_commit;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          rd_release;

  logic          dut_wr_ready [2];
  logic          dut_rd_ready [2];
  logic          dut_rd_valid [2];
  logic          dut_err      [2];
  logic [1:0]    dut_wr_bank  [2];
  logic [1:0]    dut_rd_bank  [2];
  logic [DW-1:0] dut_rd_data  [2];

  int total;
  int bad;

  for (genvar k = 0; k < 2; k++) begin : g_inst
    localparam int NB = 2 + k;
    localparam int BW = (NB <= 2) ? 1 : $clog2(NB);
    logic [BW-1:0] wb;
    logic [BW-1:0] rb;
    logic          wrdy;
    logic          rrdy;
    logic          rv;
    logic          er;
    logic [DW-1:0] rd;

    core_bank_ram #(
      .LOG_N          (12),
      .LOG_CORE_COUNT (5),
      .DATA_WIDTH     (DW),
      .NUM_BANKS      (NB)
    ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .wr_commit  (wr_commit),
      .wr_ready   (wrdy),
      .wr_bank    (wb),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .rd_release (rd_release),
      .rd_ready   (rrdy),
      .rd_bank    (rb),
      .rd_data    (rd),
      .rd_valid   (rv),
      .err        (er)
    );

    assign dut_wr_ready[k] = wrdy;
    assign dut_rd_ready[k] = rrdy;
    assign dut_rd_valid[k] = rv;
    assign dut_err[k]      = er;
    assign dut_wr_bank[k]  = 2'(wb);
    assign dut_rd_bank[k]  = 2'(rb);
    assign dut_rd_data[k]  = rd;
  end

  // Reference model, instance k has k+2 banks.
  int            m_wp    [2];
  int            m_rp    [2];
  bit            m_full  [2][3];
  logic [DW-1:0] m_mem   [2][3][DEPTH];
  bit            m_known [2][3][DEPTH];
  bit            m_err   [2];
  bit            m_pv    [2][LAT];
  logic [DW-1:0] m_pd    [2][LAT];
  bit            m_pk    [2][LAT];
  bit            m_vout  [2];
  logic [DW-1:0] m_dout  [2];
  bit            m_dk    [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int inst, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s inst%0d actual=%0h required=%0h", nm, inst, act, exp);
    end
  endtask

  task automatic model_tick();
    for (int k = 0; k < 2; k++) begin
      int nb = k + 2;
      if (!rst_n) begin
        m_wp[k] = 0;
        m_rp[k] = 0;
        for (int b = 0; b < 3; b++) m_full[k][b] = 0;
        for (int s = 0; s < LAT; s++) m_pv[k][s] = 0;
        m_err[k]  = 0;
        m_vout[k] = 0;
        m_dout[k] = '0;
        m_dk[k]   = 1;
      end else begin
        bit            wr_ok = !m_full[k][m_wp[k]];
        bit            rd_ok = m_full[k][m_rp[k]];
        bit            nv = 0;
        logic [DW-1:0] nd = '0;
        bit            nk = 0;
        if ((wr_en || wr_commit) && !wr_ok) m_err[k] = 1;
        if ((rd_en || rd_release) && !rd_ok) m_err[k] = 1;
        if (rd_en && rd_ok) begin
          nv = 1;
          nd = m_mem[k][m_rp[k]][rd_addr];
          nk = m_known[k][m_rp[k]][rd_addr];
        end
        if (wr_en && wr_ok) begin
          m_mem[k][m_wp[k]][wr_addr]   = wr_data;
          m_known[k][m_wp[k]][wr_addr] = 1;
        end
        if (wr_commit && wr_ok) begin
          m_full[k][m_wp[k]] = 1;
          m_wp[k] = (m_wp[k] + 1) % nb;
        end
        if (rd_release && rd_ok) begin
          m_full[k][m_rp[k]] = 0;
          m_rp[k] = (m_rp[k] + 1) % nb;
        end
        for (int s = LAT - 1; s > 0; s--) begin
          m_pv[k][s] = m_pv[k][s-1];
          m_pd[k][s] = m_pd[k][s-1];
          m_pk[k][s] = m_pk[k][s-1];
        end
        m_pv[k][0] = nv;
        m_pd[k][0] = nd;
        m_pk[k][0] = nk;
        m_vout[k]  = m_pv[k][LAT-1];
        if (m_vout[k]) begin
          m_dout[k] = m_pd[k][LAT-1];
          m_dk[k]   = m_pk[k][LAT-1];
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      chk("wr_ready", k, dut_wr_ready[k], !m_full[k][m_wp[k]]);
      chk("rd_ready", k, dut_rd_ready[k], m_full[k][m_rp[k]]);
      chk("wr_bank",  k, dut_wr_bank[k],  m_wp[k]);
      chk("rd_bank",  k, dut_rd_bank[k],  m_rp[k]);
      chk("rd_valid", k, dut_rd_valid[k], m_vout[k]);
      chk("err",      k, dut_err[k],      m_err[k]);
      if (m_dk[k]) chk("rd_data", k, dut_rd_data[k], m_dout[k]);
    end
  endtask

  task automatic idle();
    wr_en      = 0;
    wr_commit  = 0;
    rd_en      = 0;
    rd_release = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_tick();
    @(negedge clk);
    compare_all();
  endtask

  task automatic reset_dut();
    idle();
    rst_n = 0;
    cyc();
    rst_n = 1;
  endtask

  task automatic fill(input int base, input int step);
    for (int i = 0; i < DEPTH; i++) begin
      idle();
      wr_en   = 1;
      wr_addr = AW'(i);
      wr_data = DW'(base + step * i);
      cyc();
    end
    idle();
    wr_commit = 1;
    cyc();
    idle();
  endtask

  // Reads every word of the consumer bank, releasing it with the last read.
  task automatic drain(input int base);
    for (int i = 0; i < DEPTH + LAT; i++) begin
      idle();
      if (i < DEPTH) begin
        rd_en      = 1;
        rd_addr    = AW'(i);
        rd_release = (i == DEPTH - 1);
      end
      cyc();
      if (i >= LAT - 1 && i - (LAT - 1) < DEPTH) begin
        for (int k = 0; k < 2; k++) begin
          chk("drain_valid", k, dut_rd_valid[k], 1);
          chk("drain_data",  k, dut_rd_data[k], 64'(base + i - (LAT - 1)));
        end
      end
    end
    idle();
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    idle();
    rst_n = 0;
    repeat (2) cyc();
    rst_n = 1;

    chk("rst_wr_ready", 0, dut_wr_ready[0], 1);
    chk("rst_rd_ready", 0, dut_rd_ready[0], 0);
    chk("rst_wr_bank",  0, dut_wr_bank[0],  0);
    chk("rst_rd_bank",  0, dut_rd_bank[0],  0);
    chk("rst_rd_valid", 0, dut_rd_valid[0], 0);
    chk("rst_rd_data",  0, dut_rd_data[0],  0);
    chk("rst_err",      1, dut_err[1],      0);

    // Read while empty: ignored, flags err
    rd_en   = 1;
    rd_addr = 0;
    cyc();
    idle();
    chk("empty_rd_valid", 0, dut_rd_valid[0], 0);
    cyc();
    chk("empty_rd_valid2", 0, dut_rd_valid[0], 0);
    chk("empty_err", 0, dut_err[0], 1);

    // Fill-and-drain
    fill(100, 1);
    chk("filled_rd_ready", 0, dut_rd_ready[0], 1);
    chk("filled_wr_bank",  0, dut_wr_bank[0],  1);
    drain(100);
    chk("drained_rd_ready", 0, dut_rd_ready[0], 0);
    chk("err_held", 0, dut_err[0], 1);

    // Ping-pong overlap
    reset_dut();
    fill(7, 3);
    for (int i = 0; i < DEPTH + LAT - 1; i++) begin
      idle();
      if (i < DEPTH) begin
        wr_en      = 1;
        wr_addr    = AW'(i);
        wr_data    = DW'(1000 + i);
        rd_en      = 1;
        rd_addr    = AW'(i);
        wr_commit  = (i == DEPTH - 1);
        rd_release = (i == DEPTH - 1);
      end
      cyc();
      if (i >= LAT - 1) chk("pp_data", 0, dut_rd_data[0], 64'(7 + 3 * (i - (LAT - 1))));
      if (i == DEPTH - 1) begin
        chk("pp_wr_bank", 0, dut_wr_bank[0], 0);
        chk("pp_rd_bank", 0, dut_rd_bank[0], 1);
        chk("pp_wr_bank", 1, dut_wr_bank[1], 2);
        chk("pp_rd_bank", 1, dut_rd_bank[1], 1);
      end
    end
    idle();
    drain(1000);
    chk("pp_err", 0, dut_err[0], 0);

    // Wrap and full on the 3-bank instance
    reset_dut();
    wr_en   = 1;
    wr_addr = 0;
    wr_data = DW'(32'h55);
    cyc();
    idle();
    for (int c = 0; c < 3; c++) begin
      wr_commit = 1;
      cyc();
      idle();
    end
    chk("full_wr_ready", 1, dut_wr_ready[1], 0);
    chk("full_wr_bank",  1, dut_wr_bank[1],  0);
    chk("full_err_pre",  1, dut_err[1],      0);
    wr_en   = 1;
    wr_addr = 0;
    wr_data = DW'(32'h99);
    cyc();
    idle();
    chk("full_err", 1, dut_err[1], 1);
    rd_en   = 1;
    rd_addr = 0;
    cyc();
    idle();
    repeat (LAT - 1) cyc();
    chk("full_rd_valid", 1, dut_rd_valid[1], 1);
    chk("full_bank0",    1, dut_rd_data[1],  64'h55);

    // Write and commit in the same cycle
    reset_dut();
    wr_en     = 1;
    wr_addr   = 5;
    wr_data   = DW'(32'hABC);
    wr_commit = 1;
    cyc();
    idle();
    rd_en   = 1;
    rd_addr = 5;
    cyc();
    idle();
    repeat (LAT - 1) cyc();
    chk("wc_data", 0, dut_rd_data[0], 64'hABC);

    // Reset during a read; memory survives
    reset_dut();
    fill(500, 1);
    rd_en   = 1;
    rd_addr = 3;
    cyc();
    idle();
    rst_n = 0;
    cyc();
    rst_n = 1;
    chk("mid_rd_valid", 0, dut_rd_valid[0], 0);
    chk("mid_rd_data",  0, dut_rd_data[0],  0);
    chk("mid_rd_ready", 0, dut_rd_ready[0], 0);
    chk("mid_wr_ready", 0, dut_wr_ready[0], 1);
    wr_commit = 1;
    cyc();
    idle();
    drain(500);

    // Randomized traffic
    reset_dut();
    for (int n = 0; n < 4000; n++) begin
      wr_en      = ($urandom_range(0, 3) != 0);
      wr_addr    = AW'($urandom);
      wr_data    = DW'({$urandom, $urandom});
      wr_commit  = ($urandom_range(0, 15) == 0);
      rd_en      = ($urandom_range(0, 1) != 0);
      rd_addr    = AW'($urandom);
      rd_release = ($urandom_range(0, 15) == 0);
      rst_n      = ($urandom_range(0, 699) != 0);
      cyc();
    end
    rst_n = 1;
    idle();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/core_bank_ram.md
# core_bank_ram

Parametrised multi-bank coefficient buffer for one NTT core. It generalises the fixed two-bank, 60-bit core memory to N banks of configurable width and depth. A pointer/ownership handshake lets the producer stage fill one bank while the consumer stage drains another, with no external bank-select bookkeeping. It sits between the butterfly core's write-back path and the next stage's operand fetch.

## Interface
- LOG_N, 12: log2 of polynomial length.
- LOG_CORE_COUNT, 5: log2 of cores sharing the polynomial; ADDR_WIDTH = LOG_N-(LOG_CORE_COUNT+2); DEPTH = 2**ADDR_WIDTH.
- DATA_WIDTH, 60: coefficient word width.
- NUM_BANKS, 2: bank count, ≥2 (any integer); BANK_W = max(1, clog2(NUM_BANKS)).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_WIDTH  word address in producer bank.
- wr_data  in  DATA_WIDTH  write word.
- wr_commit  in  1  producer finished current bank.
- wr_ready  out  1  producer owns a non-full bank.
- wr_bank  out  BANK_W  producer bank index.
- rd_en  in  1  read strobe.
- rd_addr  in  ADDR_WIDTH  word address in consumer bank.
- rd_release  in  1  consumer finished current bank.
- rd_ready  out  1  consumer bank is full.
- rd_bank  out  BANK_W  consumer bank index.
- rd_data  out  DATA_WIDTH  read word.
- rd_valid  out  1  rd_data valid this cycle.
- err  out  1  sticky protocol-violation flag.

## Operation
- State: wr_ptr, rd_ptr (0..NUM_BANKS-1), full[NUM_BANKS].
- wr_ready = !full[wr_ptr]; rd_ready = full[rd_ptr].
- Accepted write (wr_en & wr_ready): bank[wr_ptr][wr_addr] <= wr_data.
- Accepted commit (wr_commit & wr_ready): full[wr_ptr] <= 1; wr_ptr advances, wrapping NUM_BANKS-1 -> 0. A write in the same cycle lands in the old bank.
- Accepted read (rd_en & rd_ready): reads bank[rd_ptr][rd_addr].
- Accepted release (rd_release & rd_ready): full[rd_ptr] <= 0; rd_ptr advances with wrap. A read in the same cycle uses the old bank.
- Commit and release in the same cycle on different banks: both apply.
- Commit and release cannot both be accepted on the same bank, because the full flag excludes it.
- All banks full: wr_ready=0. All empty: rd_ready=0.
- Violations: write/commit with !wr_ready, or read/release with !rd_ready. Each is ignored (no memory or state change) and sets err. err clears only on reset.
- Memory contents are not reset and are zero-initialised at configuration. Reset clears ownership only, so all banks are marked empty.

## Timing
- Reset values: wr_ptr=rd_ptr=0, full=0, wr_ready=1, rd_ready=0, wr_bank=rd_bank=0, rd_valid=0, rd_data=0, err=0.
- Read latency is 1 cycle: rd_valid=1 in the cycle after an accepted read.
- rd_data holds its value while rd_valid=0.
- Write-to-read: the consumer sees a bank only after commit. rd_ready rises the cycle after commit when that bank is next for the consumer.
- Reset during a read: the in-flight rd_valid is suppressed. Reset has priority over every other input.
- Full throughput: one write and one read per cycle.

## Configuration
- CORE_BANK_RAM_OUT_REG_EN defined:
  - Adds an output register stage; read latency becomes 2.
  - rd_valid and rd_data are both delayed one extra cycle.
  - Reset clears both stages.
- CORE_BANK_RAM_OUT_REG_EN undefined: latency 1 as above.

## Structure
- Package core_ram_pkg: LOG_N and DATA_WIDTH defaults, addr-width function addr_w(log_n, log_cores), bank-index width function.
- Sub-module core_ram_bank: simple dual-port block RAM (ram_style block), one write port, one registered read port, DEPTH x DATA_WIDTH.
  - Instantiated NUM_BANKS times in a generate loop.
  - Read data is muxed by the registered rd_ptr of the issuing cycle.

## Test plan
- Fill-and-drain, NUM_BANKS=2, DEPTH=32:
  - Write addr i = i+100 for i=0..31, commit.
  - Read 0..31 -> rd_data 100..131, each 1 cycle after rd_en; release -> rd_ready=0.
- Ping-pong overlap: producer fills bank1 while consumer drains bank0.
  - Both handshakes complete in the same cycle -> wr_bank=0, rd_bank=1.
  - No cross-bank corruption.
- Wrap and full, NUM_BANKS=3: commit three banks without release.
  - wr_ready=0 and wr_bank=0 after the third commit.
  - A further wr_en sets err and leaves bank0 unchanged.
- Read when empty: rd_en at reset state -> rd_valid stays 0, err=1.
  - Subsequent valid traffic still works with err held at 1.
- Same-cycle write+commit: write 0xABC to addr 5 with wr_commit.
  - Value is in the committed bank; reading addr 5 returns 0xABC.
- Reset mid-read: assert rst_n=0 in the cycle after rd_en.
  - rd_valid=0, rd_data=0, full=0.
  - Memory retains data: refill pointer without writes, commit, read -> old values.
- Repeat with CORE_BANK_RAM_OUT_REG_EN defined: all latencies checked at 2.
